div_result_bcd: RTL and testbench
=================================

Name: div_result_bcd

Overview:
- Downstream consumer of the 16/8 sequential divider's quotient/remainder outputs (Q, R, Done).
- On each new Done assertion, captures Q and R and converts both to packed BCD by sequential shift-and-add-3 (double dabble) for display/readout.
- Holds the converted result stable with a Valid flag until the next result arrives.

Parameters:
- WIDTH, 8, bit width of Q and R inputs.
- DIGITS, 3, BCD digits per output; must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Done  input  1  divider done level; a 0->1 transition marks a new result.
- Q  input  WIDTH  divider quotient, sampled on Done rise.
- R  input  WIDTH  divider remainder, sampled on Done rise.
- Q_BCD  output  4*DIGITS  packed BCD of captured Q, most significant digit in the top nibble.
- R_BCD  output  4*DIGITS  packed BCD of captured R.
- Valid  output  1  high while Q_BCD/R_BCD hold a completed conversion.
- Busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (async): Q_BCD=0, R_BCD=0, Valid=0, Busy=0, Done_d=0, Pending=0, state=IDLE, shift count=0.
- Done_d is Done registered each cycle. Rise = Done & ~Done_d. A Done already high when Reset deasserts counts as a rise on the first active edge.
- IDLE, rise seen at edge k:
  - Load shift registers with Q, R; clear BCD accumulators.
  - Clear Valid, set Busy, go SHIFT.
- SHIFT, one step per edge, WIDTH steps:
  - For each BCD nibble >= 5, add 3 to it.
  - Shift {bcd, bin} left by 1 for Q and R in parallel. Count increments.
- After the WIDTH-th step (edge k+WIDTH):
  - Write Q_BCD/R_BCD, set Valid=1, clear Busy, go IDLE.
  - Latency: rise edge to Valid = WIDTH+1 edges (9 for WIDTH=8).
- Outputs Q_BCD/R_BCD change only on a conversion's completion edge and hold until the next completion or Reset.
- Valid stays high until the next conversion loads or Reset. Done falling does not clear Valid.
- Rise while Busy (including on the completion edge):
  - Sample Q/R into a hold register and set Pending (one deep; a later rise overwrites the hold values).
  - On completion with Pending=1, Valid is set for exactly one cycle.
  - The next edge then loads from the hold register, clears Pending and Valid, and starts SHIFT.
- Rise in IDLE on the same edge a Pending load would occur: not possible (Pending loads on the edge after completion); a rise on that edge sets Pending again.
- Reset mid-conversion aborts immediately to reset values; no partial BCD is ever presented.
- Arithmetic: nibble correction is 4-bit add, no carry out (nibble <= 9 before the shift).
- Q_BCD/R_BCD nibbles are always 0-9.

Test Plan:
- Q=175, R=176, Done 0->1 -> 9 edges later Valid=1, Q_BCD=12'h175, R_BCD=12'h176; Busy high for exactly 8 cycles in between.
- Divider Reset/Done drop then Q=198, R=8, Done rises -> Valid low during conversion, then Q_BCD=12'h198, R_BCD=12'h008.
- Boundaries: Q=255, R=0 -> Q_BCD=12'h255, R_BCD=12'h000; Q=0, R=99 -> 12'h000 / 12'h099.
- Reset asserted at step 4 of a conversion -> all outputs 0 asynchronously. After release with Done held high: one conversion runs, then the correct result appears.
- Second Done rise (Q=10, R=1) during a conversion of Q=175, R=176:
  - First completion shows 12'h175/12'h176 with Valid high one cycle.
  - Then Valid=0, Busy=1, and the final result is 12'h010/12'h001.
- Done held high for 100 cycles after one rise -> exactly one conversion; Q/R changes while Done stays high do not alter Q_BCD/R_BCD.

Source files
------------

// File: rtl/div_result_bcd.sv
// Captures the divider's quotient/remainder on each Done rise and converts both
// to packed BCD with a bit-serial double-dabble, holding the result under Valid.
module div_result_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Done,
    input  logic [WIDTH-1:0]    Q,
    input  logic [WIDTH-1:0]    R,
    output logic [4*DIGITS-1:0] Q_BCD,
    output logic [4*DIGITS-1:0] R_BCD,
    output logic                Valid,
    output logic                Busy
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state, state_nxt;
    logic                 done_d, pending;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     q_bin, r_bin, hold_q, hold_r;
    logic [BW-1:0]        q_acc, r_acc;
    logic [BW+WIDTH-1:0]  q_step, r_step;
    logic                 rise, load, load_hold, last_step;

    // One double-dabble step: correct every nibble >= 5, then shift {bcd, bin} left.
    function automatic logic [BW+WIDTH-1:0] dd_step(input logic [BW-1:0]    acc,
                                                    input logic [WIDTH-1:0] bin);
        logic [BW-1:0] adj;
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        return {adj, bin} << 1;
    endfunction

    assign rise   = Done & ~done_d;
    assign q_step = dd_step(q_acc, q_bin);
    assign r_step = dd_step(r_acc, r_bin);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_hold = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                // A result queued during the previous conversion takes priority.
                if (pending) begin
                    load      = 1'b1;
                    load_hold = 1'b1;
                    state_nxt = SHIFT;
                end else if (rise) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last_step = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            done_d  <= 1'b0;
            pending <= 1'b0;
            cnt     <= '0;
            Valid   <= 1'b0;
            Busy    <= 1'b0;
            Q_BCD   <= '0;
            R_BCD   <= '0;
        end else begin
            state  <= state_nxt;
            done_d <= Done;
            if (load) begin
                cnt   <= '0;
                Valid <= 1'b0;
                Busy  <= 1'b1;
            end else if (state == SHIFT) begin
                cnt <= cnt + 1'b1;
            end
            if (last_step) begin
                Q_BCD <= q_step[BW+WIDTH-1:WIDTH];
                R_BCD <= r_step[BW+WIDTH-1:WIDTH];
                Valid <= 1'b1;
                Busy  <= 1'b0;
            end
            // A rise on the hold-load edge re-arms the queue with the new values.
            if (load_hold)
                pending <= rise;
            else if (rise && state == SHIFT)
                pending <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rise && (state == SHIFT || load_hold)) begin
            hold_q <= Q;
            hold_r <= R;
        end
        if (load) begin
            q_acc <= '0;
            r_acc <= '0;
            q_bin <= load_hold ? hold_q : Q;
            r_bin <= load_hold ? hold_r : R;
        end else if (state == SHIFT) begin
            {q_acc, q_bin} <= q_step;
            {r_acc, r_bin} <= r_step;
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd: table of conversions plus reset, queued-result
// and held-Done sequences.
module tb_div_result_bcd;
    logic        clk;
    logic        rst;
    logic        done;
    logic [7:0]  q, r;
    logic [11:0] q_bcd, r_bcd;
    logic        valid, busy;

    int checks = 0;
    int errors = 0;

    div_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .CLK(clk), .Reset(rst), .Done(done), .Q(q), .R(r),
        .Q_BCD(q_bcd), .R_BCD(r_bcd), .Valid(valid), .Busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  q;
        logic [7:0]  r;
        logic [11:0] eq;
        logic [11:0] er;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
        end while (!valid && lat < 30);
    endtask

    initial begin
        int lat, busy_n;

        vecs[0] = '{8'd175, 8'd176, 12'h175, 12'h176};
        vecs[1] = '{8'd198, 8'd8,   12'h198, 12'h008};
        vecs[2] = '{8'd255, 8'd0,   12'h255, 12'h000};
        vecs[3] = '{8'd0,   8'd99,  12'h000, 12'h099};
        vecs[4] = '{8'd10,  8'd1,   12'h010, 12'h001};
        vecs[5] = '{8'd100, 8'd200, 12'h100, 12'h200};
        vecs[6] = '{8'd9,   8'd90,  12'h009, 12'h090};

        rst = 1'b1; done = 1'b0; q = '0; r = '0;
        repeat (2) @(negedge clk);
        check("reset_q_bcd", 32'(q_bcd), 32'h0);
        check("reset_r_bcd", 32'(r_bcd), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            done = 1'b0;
            @(negedge clk);
            if (i > 0) check($sformatf("valid_after_done_fall_%0d", i), 32'(valid), 32'h1);
            q = vecs[i].q;
            r = vecs[i].r;
            done = 1'b1;
            wait_valid(lat, busy_n);
            check($sformatf("latency_%0d", i), 32'(lat), 32'd9);
            check($sformatf("busy_cycles_%0d", i), 32'(busy_n), 32'd8);
            check($sformatf("q_bcd_%0d", i), 32'(q_bcd), 32'(vecs[i].eq));
            check($sformatf("r_bcd_%0d", i), 32'(r_bcd), 32'(vecs[i].er));
        end

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        q = 8'd175; r = 8'd176; done = 1'b1;
        repeat (5) @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("abort_q_bcd", 32'(q_bcd), 32'h0);
        check("abort_r_bcd", 32'(r_bcd), 32'h0);
        check("abort_valid", 32'(valid), 32'h0);
        check("abort_busy",  32'(busy),  32'h0);
        @(negedge clk);
        q = 8'd123; r = 8'd45;
        rst = 1'b0;
        wait_valid(lat, busy_n);
        check("post_reset_latency", 32'(lat), 32'd9);
        check("post_reset_q_bcd", 32'(q_bcd), 32'h123);
        check("post_reset_r_bcd", 32'(r_bcd), 32'h045);

        // Done held high with wandering Q/R: no further conversion.
        busy_n = 0;
        for (int c = 0; c < 100; c++) begin
            q = 8'($urandom);
            r = 8'($urandom);
            @(negedge clk);
            if (busy) busy_n++;
        end
        check("held_done_busy", 32'(busy_n), 32'd0);
        check("held_done_valid", 32'(valid), 32'h1);
        check("held_done_q_bcd", 32'(q_bcd), 32'h123);
        check("held_done_r_bcd", 32'(r_bcd), 32'h045);

        // Second rise during a conversion is queued and converted afterwards.
        done = 1'b0;
        @(negedge clk);
        q = 8'd175; r = 8'd176; done = 1'b1;
        repeat (3) @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        q = 8'd10; r = 8'd1; done = 1'b1;
        @(negedge clk);
        q = 8'd77; r = 8'd66;
        wait_valid(lat, busy_n);
        check("first_latency", 32'(lat), 32'd4);
        check("first_q_bcd", 32'(q_bcd), 32'h175);
        check("first_r_bcd", 32'(r_bcd), 32'h176);
        check("first_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("queued_valid_drop", 32'(valid), 32'h0);
        check("queued_busy", 32'(busy), 32'h1);
        wait_valid(lat, busy_n);
        check("queued_latency", 32'(lat), 32'd8);
        check("queued_q_bcd", 32'(q_bcd), 32'h010);
        check("queued_r_bcd", 32'(r_bcd), 32'h001);
        repeat (3) @(negedge clk);
        check("queued_no_rerun", 32'(busy), 32'h0);
        check("queued_valid_hold", 32'(valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
